// File: rtl/pkg_segment.sv
// Types and constants shared by the numeric converter and the 7-segment string driver.
package pkg_segment;

  typedef logic [3:0] t_digit;

  localparam t_digit C_DIGIT_MAX = 4'd9;

  typedef enum logic {StIdle, StShift} t_cnv_state;

  // 10^n as a 64-bit constant; only used to size elaboration-time limits.
  function automatic logic [63:0] f_pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnv_dabble_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module cnv_dabble_adj
  import pkg_segment::*;
(
  input  t_digit digit_i,
  output t_digit digit_o
);

  // Adding 3 to 5..9 makes the following left shift carry into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/cnv_bin2dec_w.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// saturation to all nines when the input does not fit in p_width digits.
module cnv_bin2dec_w
  import pkg_segment::*;
#(
  parameter int unsigned p_width     = 4,
  parameter int unsigned p_bin_width = 14
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [p_bin_width-1:0] i_bin,
  output t_digit [p_width-1:0]   o_value,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_ovf
);

  localparam int unsigned BcdW = 4 * p_width;
  localparam int unsigned SrW  = BcdW + p_bin_width;
  localparam int unsigned CntW = $clog2(p_bin_width + 1);

  localparam logic [63:0]     CMax    = f_pow10(p_width) - 64'd1;
  localparam logic [CntW-1:0] CntLast = CntW'(p_bin_width - 1);

  t_cnv_state           state_q, state_d;
  logic [SrW-1:0]       sr_q, sr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovf_flag_q, ovf_flag_d;
  t_digit [p_width-1:0] value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  t_digit [p_width-1:0] bcd_adj;
  logic [SrW-1:0]       sr_adj;
  logic [SrW-1:0]       sr_shift;

  // Per-digit correction of the BCD part of the shift register.
  for (genvar g = 0; g < p_width; g++) begin : g_adj
    cnv_dabble_adj u_adj (
      .digit_i (sr_q[p_bin_width + 4*g +: 4]),
      .digit_o (bcd_adj[g])
    );
  end

  assign sr_adj   = {bcd_adj, sr_q[p_bin_width-1:0]};
  // The top bit falls off; only overflowing inputs ever reach it and those saturate.
  assign sr_shift = {sr_adj[SrW-2:0], 1'b0};

  // Next-state: accept in idle, shift p_bin_width times, then publish the result.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    value_d    = value_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          sr_d       = {{BcdW{1'b0}}, i_bin};
          cnt_d      = '0;
          ovf_flag_d = 64'(i_bin) > CMax;
          state_d    = StShift;
        end
      end
      StShift: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
          ovf_d   = ovf_flag_q;
          value_d = ovf_flag_q ? {p_width{C_DIGIT_MAX}} : sr_shift[SrW-1 -: BcdW];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      value_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      value_q    <= value_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign o_value = value_q;
  assign o_busy  = (state_q == StShift);
  assign o_done  = done_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_cnv_bin2dec_w.sv
// Directed bench for cnv_bin2dec_w at default parameters (4 digits, 14-bit input).
module tb_cnv_bin2dec_w;
  import pkg_segment::*;

  localparam int unsigned W  = 4;
  localparam int unsigned BW = 14;
  localparam int          Lat = 14;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [BW-1:0]        bin = '0;
  t_digit [W-1:0]       value;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BW-1:0] bin;
    logic [15:0]   digits;
    logic          ovf;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  cnv_bin2dec_w #(
    .p_width     (W),
    .p_bin_width (BW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bin   (bin),
    .o_value (value),
    .o_busy  (busy),
    .o_done  (done),
    .o_ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input logic [BW-1:0] b);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = BW'($urandom);
  endtask

  // Wait (bounded) for o_done; counts edges and busy samples along the way.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic convert(input string name, input logic [BW-1:0] b, input logic [15:0] exp_d,
                         input logic exp_ovf);
    int cyc;
    int bc;
    launch(b);
    check({name, "_busy_e0"}, 32'(busy), 32'd1);
    wait_done(cyc, bc);
    check({name, "_latency"}, cyc, Lat);
    check({name, "_busy_len"}, bc + 1, Lat);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_value"}, 32'(value), 32'(exp_d));
    check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    @(posedge clk);
    #1;
    check({name, "_done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int bc;
    int held_bad;
    int extra_done;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd10000, 16'h9999, 1'b1};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1};
    vecs[5] = '{14'd1,     16'h0001, 1'b0};
    vecs[6] = '{14'd10,    16'h0010, 1'b0};
    vecs[7] = '{14'd999,   16'h0999, 1'b0};
    vecs[8] = '{14'd4096,  16'h4096, 1'b0};
    vecs[9] = '{14'd8191,  16'h8191, 1'b0};

    #1;
    check("rst_value", 32'(value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      convert($sformatf("v%0d", i), vecs[i].bin, vecs[i].digits, vecs[i].ovf);
    end

    // Start during busy must be ignored.
    launch(14'd42);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd7777;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bc);
    check("ign_latency", cyc, Lat - 5);
    check("ign_value", 32'(value), 32'h0042);
    check("ign_ovf", 32'(ovf), 32'd0);
    extra_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    check("ign_no_second_done", extra_done, 0);
    check("ign_idle", 32'(busy), 32'd0);

    // Back-to-back: second start lands on the done cycle.
    launch(14'd1234);
    wait_done(cyc, bc);
    check("b2b_first_latency", cyc, Lat);
    check("b2b_first_value", 32'(value), 32'h1234);
    launch(14'd5678);
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_done_fall", 32'(done), 32'd0);
    cyc = 0;
    held_bad = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && value !== 16'h1234) held_bad++;
    end
    check("b2b_value_held", held_bad, 0);
    check("b2b_second_latency", cyc, Lat);
    check("b2b_second_value", 32'(value), 32'h5678);

    // Leave a saturated result behind so the reset visibly clears it.
    convert("pre_rst", 14'd16383, 16'h9999, 1'b1);

    // Asynchronous reset mid-conversion.
    launch(14'd4321);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    check("midrst_no_done", extra_done, 0);
    convert("post_rst", 14'd4321, 16'h4321, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
